// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage with single-outstanding imem handshake,
//            stall hold buffer, branch redirect/flush and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write_en_in,
    input  logic        if_id_write_en_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] if_id_pc_out,
    output logic [31:0] if_id_pc_4_out,
    output logic [31:0] if_id_instr_out
);

    localparam logic [1:0] c_st_req  = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;
    localparam logic [1:0] c_st_drop = 2'd3;

    logic [1:0]  r_state_q,       w_state_d;
    logic [31:0] r_pc_q,          w_pc_d;
    logic [31:0] r_buf_q,         w_buf_d;
    logic [31:0] r_if_id_pc_q,    w_if_id_pc_d;
    logic [31:0] r_if_id_pc_4_q,  w_if_id_pc_4_d;
    logic [31:0] r_if_id_instr_q, w_if_id_instr_d;

    logic        w_load;
    logic [31:0] w_instr;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc_q + 32'd4;

    always_comb begin
        w_state_d = r_state_q;
        w_buf_d   = r_buf_q;
        w_load    = 1'b0;
        w_instr   = r_buf_q;

        case (r_state_q)
            c_st_req: begin
                if (branch_taken_in) begin
                    w_state_d = imem_gnt_in ? c_st_drop : c_st_req;
                end else if (imem_gnt_in) begin
                    w_state_d = c_st_wait;
                end
            end
            c_st_wait: begin
                if (branch_taken_in) begin
                    w_state_d = imem_rvalid_in ? c_st_req : c_st_drop;
                end else if (imem_rvalid_in) begin
                    if (if_id_write_en_in) begin
                        w_load    = 1'b1;
                        w_instr   = imem_rdata_in;
                        w_state_d = c_st_req;
                    end else begin
                        w_buf_d   = imem_rdata_in;
                        w_state_d = c_st_hold;
                    end
                end
            end
            c_st_hold: begin
                if (branch_taken_in) begin
                    w_buf_d   = 32'd0;
                    w_state_d = c_st_req;
                end else if (if_id_write_en_in) begin
                    w_load    = 1'b1;
                    w_state_d = c_st_req;
                end
            end
            default: begin
                // Data for a fetch killed by a branch is dropped on arrival.
                if (imem_rvalid_in) begin
                    w_state_d = c_st_req;
                end
            end
        endcase
    end

    always_comb begin
        w_pc_d          = r_pc_q;
        w_if_id_pc_d    = r_if_id_pc_q;
        w_if_id_pc_4_d  = r_if_id_pc_4_q;
        w_if_id_instr_d = r_if_id_instr_q;

        if (branch_taken_in) begin
            w_pc_d          = branch_target_in;
            w_if_id_pc_d    = 32'd0;
            w_if_id_pc_4_d  = 32'd0;
            w_if_id_instr_d = NOP_INSTR;
        end else if (w_load) begin
            w_if_id_pc_d    = r_pc_q;
            w_if_id_pc_4_d  = w_pc_plus4;
            w_if_id_instr_d = w_instr;
            if (pc_write_en_in) begin
                w_pc_d = w_pc_plus4;
            end
        end else if (if_id_write_en_in) begin
            w_if_id_pc_d    = 32'd0;
            w_if_id_pc_4_d  = 32'd0;
            w_if_id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= c_st_req;
            r_pc_q          <= RESET_PC;
            r_buf_q         <= 32'd0;
            r_if_id_pc_q    <= 32'd0;
            r_if_id_pc_4_q  <= 32'd0;
            r_if_id_instr_q <= NOP_INSTR;
        end else begin
            r_state_q       <= w_state_d;
            r_pc_q          <= w_pc_d;
            r_buf_q         <= w_buf_d;
            r_if_id_pc_q    <= w_if_id_pc_d;
            r_if_id_pc_4_q  <= w_if_id_pc_4_d;
            r_if_id_instr_q <= w_if_id_instr_d;
        end
    end

    assign imem_req_out    = (r_state_q == c_st_req) && !rst;
    assign imem_addr_out   = r_pc_q;
    assign if_id_pc_out    = r_if_id_pc_q;
    assign if_id_pc_4_out  = r_if_id_pc_4_q;
    assign if_id_instr_out = r_if_id_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Randomized scoreboard bench for if_stage against a transaction-
//            level fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          N_CYCLES  = 4000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write_en_in;
    logic        if_id_write_en_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] if_id_pc_out;
    logic [31:0] if_id_pc_4_out;
    logic [31:0] if_id_instr_out;

    ifid_t       q_ifid[$];
    logic [31:0] q_addr[$];
    int          vectors     = 0;
    int          miscompares = 0;

    if_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_write_en_in    (pc_write_en_in),
        .if_id_write_en_in (if_id_write_en_in),
        .branch_taken_in   (branch_taken_in),
        .branch_target_in  (branch_target_in),
        .imem_req_out      (imem_req_out),
        .imem_addr_out     (imem_addr_out),
        .imem_gnt_in       (imem_gnt_in),
        .imem_rvalid_in    (imem_rvalid_in),
        .imem_rdata_in     (imem_rdata_in),
        .if_id_pc_out      (if_id_pc_out),
        .if_id_pc_4_out    (if_id_pc_4_out),
        .if_id_instr_out   (if_id_instr_out)
    );

    always #5 clk = ~clk;

    // Stimulus, memory responder and reference model
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        logic [31:0] m_pc, m_buf, instr, pc4;
        bit          m_busy, m_stale, m_hbuf, hs, arrived, avail;
        ifid_t       m_ifid;
        ifid_t       bubble;

        bubble            = '{32'd0, 32'd0, NOP_INSTR};
        pend              = 1'b0;
        cnt               = 0;
        paddr             = 32'd0;
        m_pc              = RESET_PC;
        m_buf             = 32'd0;
        m_busy            = 1'b0;
        m_stale           = 1'b0;
        m_hbuf            = 1'b0;
        m_ifid            = bubble;
        rst               = 1'b1;
        pc_write_en_in    = 1'b1;
        if_id_write_en_in = 1'b1;
        branch_taken_in   = 1'b0;
        branch_target_in  = 32'd0;
        imem_gnt_in       = 1'b0;
        imem_rvalid_in    = 1'b0;
        imem_rdata_in     = 32'd0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            rst               = (cyc < 3) || ($urandom_range(0, 99) < 2);
            pc_write_en_in    = ($urandom_range(0, 99) < 85);
            if_id_write_en_in = ($urandom_range(0, 99) < 70);
            branch_taken_in   = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 3))
                0:       branch_target_in = 32'h0000_0100;
                1:       branch_target_in = 32'hFFFF_FFFC;
                2:       branch_target_in = 32'hFFFF_FFF8;
                default: branch_target_in = $urandom & 32'hFFFF_FFFC;
            endcase

            imem_rvalid_in = 1'b0;
            imem_rdata_in  = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid_in = 1'b1;
                    imem_rdata_in  = paddr ^ 32'h5A5A_A5A5;
                    pend           = 1'b0;
                end
            end
            imem_gnt_in = !pend && !imem_rvalid_in && ($urandom_range(0, 99) < 70);
            #1;
            if (imem_req_out && imem_gnt_in) begin
                pend  = 1'b1;
                paddr = imem_addr_out;
                cnt   = $urandom_range(1, 3);
            end

            if (rst) begin
                m_pc    = RESET_PC;
                m_busy  = 1'b0;
                m_stale = 1'b0;
                m_hbuf  = 1'b0;
                m_ifid  = bubble;
            end else begin
                hs      = !m_busy && !m_hbuf && imem_gnt_in;
                if (hs) q_addr.push_back(m_pc);
                arrived = m_busy && imem_rvalid_in;
                avail   = (arrived && !m_stale) || m_hbuf;
                instr   = (arrived && !m_stale) ? imem_rdata_in : m_buf;
                if (branch_taken_in) begin
                    m_ifid  = bubble;
                    m_pc    = branch_target_in;
                    m_hbuf  = 1'b0;
                    m_busy  = hs || (m_busy && !imem_rvalid_in);
                    m_stale = m_busy;
                end else begin
                    if (avail && if_id_write_en_in) begin
                        pc4    = m_pc + 32'd4;
                        m_ifid = '{m_pc, pc4, instr};
                        if (pc_write_en_in) m_pc = pc4;
                        m_hbuf = 1'b0;
                    end else if (avail) begin
                        m_hbuf = 1'b1;
                        m_buf  = instr;
                    end else if (if_id_write_en_in) begin
                        m_ifid = bubble;
                    end
                    if (hs) begin
                        m_busy  = 1'b1;
                        m_stale = 1'b0;
                    end else if (arrived) begin
                        m_busy  = 1'b0;
                        m_stale = 1'b0;
                    end
                end
            end
            q_ifid.push_back(m_ifid);
        end

        repeat (2) @(posedge clk);
        #3;
        vectors++;
        if (q_addr.size() != 0 || q_ifid.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d fetch addrs and %0d IF/ID words expected but never observed",
                     q_addr.size(), q_ifid.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Fetch-request monitor: every accepted request must match the model address
    initial begin
        logic [31:0] exp_addr;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                vectors++;
                if (imem_req_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL req_in_reset: imem_req_out=%b expected 0", imem_req_out);
                end
            end else if (imem_req_out === 1'b1 && imem_gnt_in === 1'b1) begin
                vectors++;
                if (q_addr.size() == 0) begin
                    miscompares++;
                    $display("FAIL fetch_addr: unexpected request addr=%h", imem_addr_out);
                end else begin
                    exp_addr = q_addr.pop_front();
                    if (imem_addr_out !== exp_addr) begin
                        miscompares++;
                        $display("FAIL fetch_addr: got %h expected %h", imem_addr_out, exp_addr);
                    end
                end
            end
        end
    end

    // IF/ID monitor: register contents after each edge
    initial begin
        ifid_t exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (q_ifid.size() != 0) begin
                exp_v = q_ifid.pop_front();
                vectors++;
                if (if_id_pc_out !== exp_v.pc || if_id_pc_4_out !== exp_v.pc4 ||
                    if_id_instr_out !== exp_v.instr) begin
                    miscompares++;
                    $display("FAIL if_id: got {%h,%h,%h} expected {%h,%h,%h}",
                             if_id_pc_out, if_id_pc_4_out, if_id_instr_out,
                             exp_v.pc, exp_v.pc4, exp_v.instr);
                end
            end
        end
    end

endmodule
`default_nettype wire
